// File: rtl/cfd_cfg_receiver.sv
// rtl/cfd_cfg_receiver.sv - byte-wide configuration bus receiver with 16-channel register file
module cfd_cfg_receiver #(
   parameter int ADDRBITS       = 4,
   parameter int DATABITS       = 8,
   parameter int MODEBITS       = 4,
   parameter int CHANNELS       = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter logic [DATABITS-1:0] DAC_RESET = 8'h80
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         STB,
   input  logic [DATABITS-1:0]          DATA,
   output logic [CHANNELS*DATABITS-1:0] CH_DAC,
   output logic [CHANNELS-1:0]          CH_EN,
   output logic                         NEG_POL,
   output logic                         AGND_INT_DISABLE,
   output logic                         GEN,
   output logic                         BUSY,
   output logic                         WR_DONE,
   output logic                         ERR
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [MODEBITS-1:0] M_DAC   = MODEBITS'(4'h0);
   localparam logic [MODEBITS-1:0] M_EN    = MODEBITS'(4'h1);
   localparam logic [MODEBITS-1:0] M_GLB   = MODEBITS'(4'h2);
   localparam logic [MODEBITS-1:0] M_BDAC  = MODEBITS'(4'h3);
   localparam logic [MODEBITS-1:0] M_BEN   = MODEBITS'(4'h4);
   localparam logic [MODEBITS-1:0] M_CLRE  = MODEBITS'(4'hE);
   localparam logic [MODEBITS-1:0] M_RESET = MODEBITS'(4'hF);

   typedef enum logic {IDLE, HDR} state_t;

   state_t                state;
   logic [SYNC_STAGES-1:0] stb_sync;
   logic                  stb_d;
   logic                  rise;
   logic [MODEBITS-1:0]   mode;
   logic [ADDRBITS-1:0]   addr;
   logic [TW-1:0]         tcnt;
   logic [DATABITS-1:0]   dac [CHANNELS];

   for (genvar g = 0; g < CHANNELS; g++) begin : g_dac
      assign CH_DAC[g*DATABITS +: DATABITS] = dac[g];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stb_sync         <= '0;
         stb_d            <= 1'b0;
         rise             <= 1'b0;
         state            <= IDLE;
         mode             <= '0;
         addr             <= '0;
         tcnt             <= '0;
         for (int i = 0; i < CHANNELS; i++) dac[i] <= DAC_RESET;
         CH_EN            <= '0;
         NEG_POL          <= 1'b0;
         AGND_INT_DISABLE <= 1'b0;
         GEN              <= 1'b0;
         BUSY             <= 1'b0;
         WR_DONE          <= 1'b0;
         ERR              <= 1'b0;
      end else begin
         stb_sync <= {stb_sync[SYNC_STAGES-2:0], STB};
         stb_d    <= stb_sync[SYNC_STAGES-1];
         // registered one-cycle pulse; DATA is sampled while it is high
         rise     <= stb_sync[SYNC_STAGES-1] & ~stb_d;
         WR_DONE  <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  mode  <= DATA[DATABITS-1 -: MODEBITS];
                  addr  <= DATA[ADDRBITS-1:0];
                  tcnt  <= '0;
                  BUSY  <= 1'b1;
                  state <= HDR;
               end
            end
            HDR: begin
               if (rise) begin
                  state   <= IDLE;
                  BUSY    <= 1'b0;
                  WR_DONE <= 1'b1;
                  case (mode)
                     M_DAC:  dac[addr] <= DATA;
                     M_EN:   CH_EN[addr] <= DATA[0];
                     M_GLB: begin
                        NEG_POL          <= DATA[0];
                        AGND_INT_DISABLE <= DATA[1];
                        GEN              <= DATA[2];
                     end
                     M_BDAC: for (int i = 0; i < CHANNELS; i++) dac[i] <= DATA;
                     M_BEN:  CH_EN <= {CHANNELS{DATA[0]}};
                     M_CLRE: ERR <= 1'b0;
                     M_RESET: begin
                        for (int i = 0; i < CHANNELS; i++) dac[i] <= DAC_RESET;
                        CH_EN            <= '0;
                        NEG_POL          <= 1'b0;
                        AGND_INT_DISABLE <= 1'b0;
                        GEN              <= 1'b0;
                     end
                     default: ERR <= 1'b1;
                  endcase
               end else if (tcnt == TLIM) begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
                  ERR   <= 1'b1;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cfd_cfg_receiver.sv
// tb/tb_cfd_cfg_receiver.sv - randomized self-checking bench against a frame-level reference model
module tb_cfd_cfg_receiver;

   localparam int S = 2;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         STB = 1'b0;
   logic [7:0]   DATA = 8'h00;
   logic [127:0] CH_DAC;
   logic [15:0]  CH_EN;
   logic         NEG_POL, AGND_INT_DISABLE, GEN, BUSY, WR_DONE, ERR;

   cfd_cfg_receiver dut (
      .CLK(CLK), .RST(RST), .STB(STB), .DATA(DATA),
      .CH_DAC(CH_DAC), .CH_EN(CH_EN), .NEG_POL(NEG_POL),
      .AGND_INT_DISABLE(AGND_INT_DISABLE), .GEN(GEN),
      .BUSY(BUSY), .WR_DONE(WR_DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   int wr_cnt = 0;
   int last_wr_cyc = 0;
   int rise_cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   always @(posedge CLK) cyc <= cyc + 1;
   always @(negedge CLK) if (WR_DONE) begin wr_cnt++; last_wr_cyc = cyc; end

   // reference model: state of the register file as a set of plain values
   logic [7:0]  m_dac [16];
   logic [15:0] m_en;
   logic        m_neg, m_agnd, m_gen, m_err, m_pend;
   logic [7:0]  m_hdr;
   int          m_wr = 0;

   function automatic void m_reset_cfg();
      for (int i = 0; i < 16; i++) m_dac[i] = 8'h80;
      m_en = '0; m_neg = 0; m_agnd = 0; m_gen = 0;
   endfunction

   function automatic void m_byte(input logic [7:0] b);
      int md, ad;
      if (!m_pend) begin
         m_hdr = b; m_pend = 1;
         return;
      end
      m_pend = 0; m_wr++;
      md = int'(m_hdr) / 16; ad = int'(m_hdr) % 16;
      case (md)
         0: m_dac[ad] = b;
         1: m_en[ad] = b[0];
         2: begin m_neg = b[0]; m_agnd = b[1]; m_gen = b[2]; end
         3: for (int i = 0; i < 16; i++) m_dac[i] = b;
         4: m_en = b[0] ? 16'hFFFF : 16'h0000;
         14: m_err = 0;
         15: m_reset_cfg();
         default: m_err = 1;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [127:0] ed;
      for (int i = 0; i < 16; i++) ed[i*8 +: 8] = m_dac[i];
      @(negedge CLK);
      chk({tag, ".dac"}, CH_DAC, ed);
      chk({tag, ".en"}, CH_EN, m_en);
      chk({tag, ".glb"}, {NEG_POL, AGND_INT_DISABLE, GEN}, {m_neg, m_agnd, m_gen});
      chk({tag, ".err"}, ERR, m_err);
      chk({tag, ".busy"}, BUSY, m_pend);
      chk({tag, ".wrcnt"}, wr_cnt, m_wr);
   endtask

   task automatic do_reset();
      @(negedge CLK); RST = 1;
      repeat (2) @(posedge CLK);
      @(negedge CLK); RST = 0;
      m_reset_cfg(); m_err = 0; m_pend = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge CLK);
      #($urandom_range(1, 9));
      DATA = b; STB = 1; rise_cyc = cyc;
      m_byte(b);
      repeat (6) @(posedge CLK);
      #1 STB = 0;
      repeat (6) @(posedge CLK);
   endtask

   task automatic frame(input logic [7:0] h, input logic [7:0] d);
      send_byte(h);
      send_byte(d);
   endtask

   initial begin
      logic [7:0] h, d;
      m_reset_cfg(); m_err = 0; m_pend = 0;
      do_reset();
      check_all("reset");

      send_byte(8'h05);
      check_all("dac5_hdr");
      frame_tail: begin
         send_byte(8'h3C);
         chk("wr_latency", last_wr_cyc - rise_cyc, S + 2);
         check_all("dac5");
      end

      frame(8'h20, 8'h07); check_all("globals");
      frame(8'h30, 8'hA5); check_all("bcast_dac");
      frame(8'h40, 8'h01); check_all("bcast_en");
      frame(8'hF0, 8'h00); check_all("cfg_reset");

      send_byte(8'h03);
      repeat (1100) @(posedge CLK);
      m_pend = 0; m_err = 1;
      check_all("timeout");
      frame(8'hE0, 8'h00); check_all("clr_err");
      frame(8'h03, 8'h11); check_all("dac3");

      frame(8'h75, 8'hFF); check_all("illegal");

      send_byte(8'h02);
      do_reset();
      send_byte(8'h55);
      check_all("rst_mid");
      send_byte(8'hFF);
      check_all("rst_mid_done");

      for (int i = 0; i < 200; i++) begin
         h = 8'($urandom);
         d = 8'($urandom);
         frame(h, d);
         check_all($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cfd_cfg_receiver.md
Name: cfd_cfg_receiver

Overview:
- Chip-side receiver for the byte-wide configuration bus (DATA[7:0] + STB) driven by the CFD test driver.
- Synchronises the asynchronous STB and decodes two-byte frames: a header {MODE[3:0], ADDR[3:0]}, then a data byte.
- Updates the 16-channel configuration register file: per-channel 8-bit DAC, per-channel enable, and global NEG_POL / AGND_INT_DISABLE / GEN.
- Sits between the chip pads and the analog channel front-ends.

Parameters:
- ADDRBITS, 4, channel address width.
- DATABITS, 8, data bus and DAC word width.
- MODEBITS, 4, command mode width; ADDRBITS+MODEBITS must equal DATABITS.
- CHANNELS, 16, number of channels (2**ADDRBITS).
- SYNC_STAGES, 2, STB synchroniser depth (minimum 2).
- TIMEOUT_CYCLES, 1024, maximum CLK cycles allowed between header and data byte.
- DAC_RESET, 8'h80, reset value of every channel DAC register.

Ports:
- CLK  in  1  system clock; all state is on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- STB  in  1  byte strobe from the driver, asynchronous to CLK.
- DATA  in  DATABITS  byte bus; stable from STB rise until STB fall.
- CH_DAC  out  CHANNELS*DATABITS  per-channel DAC codes; channel n occupies [n*8+7:n*8].
- CH_EN  out  CHANNELS  per-channel trigger enable.
- NEG_POL  out  1  negative input polarity select.
- AGND_INT_DISABLE  out  1  internal AGND disable.
- GEN  out  1  test-pulse generator enable.
- BUSY  out  1  high while a header is held and the data byte is pending.
- WR_DONE  out  1  one-cycle pulse when a frame is accepted.
- ERR  out  1  sticky error flag.

Behaviour:
- Reset: applies to every output and all state on the first CLK edge with RST=1.
  - CH_DAC = DAC_RESET in every channel.
  - CH_EN = 0; NEG_POL = AGND_INT_DISABLE = GEN = 0.
  - BUSY = WR_DONE = ERR = 0.
  - Synchroniser flops cleared; FSM in IDLE; timeout counter cleared.
- RST mid-frame: the held header is discarded and no register write occurs.
- Synchroniser and edge detect:
  - STB passes through SYNC_STAGES flops, then one edge-detect flop.
  - The rising edge is seen SYNC_STAGES+1 cycles after STB rises.
  - DATA is sampled directly in the edge-detect cycle.
  - Driver contract: STB high for at least SYNC_STAGES+2 cycles and low for at least SYNC_STAGES+2 cycles.
  - Only rising edges are acted on; STB held high produces no repeat action.
- FSM has two states, IDLE and HDR.
  - IDLE, on edge: latch MODE=DATA[7:4] and ADDR=DATA[3:0], go to HDR, BUSY=1 from the next cycle, clear the timeout counter.
  - HDR, on edge: execute the command with the sampled byte D. Register outputs and WR_DONE=1 update together on the next cycle. Return to IDLE with BUSY=0.
  - HDR, no edge: increment the timeout counter. When it reaches TIMEOUT_CYCLES-1 with no edge: go to IDLE, set ERR=1, no write, no WR_DONE.
  - Edge in the same cycle as the timeout limit: the edge wins and the frame completes normally.
- Commands (MODE value):
  - 0x0: CH_DAC[ADDR] = D.
  - 0x1: CH_EN[ADDR] = D[0].
  - 0x2: NEG_POL = D[0], AGND_INT_DISABLE = D[1], GEN = D[2]. ADDR and D[7:3] are ignored.
  - 0x3: every CH_DAC = D (broadcast).
  - 0x4: every CH_EN = D[0] (broadcast).
  - 0xE: ERR = 0.
  - 0xF: all configuration registers return to reset values; ERR is unchanged.
  - All other modes: no write, ERR = 1, WR_DONE still pulses (frame consumed).
- Latency: STB rise of the data byte to updated outputs and WR_DONE is SYNC_STAGES+2 CLK cycles.
- ERR is set on timeout or an illegal mode. It is cleared only by RST or mode 0xE and has priority-free set/clear because the two never coincide.
- Glitch rule: an STB pulse shorter than one CLK period may be missed. A missed byte is not an error unless it causes a timeout.

Test Plan:
- Reset check: drive RST=1 for 2 cycles -> every CH_DAC=8'h80, CH_EN=16'h0000, NEG_POL=AGND_INT_DISABLE=GEN=0, BUSY=WR_DONE=ERR=0.
- Single DAC write: frames {0x0,0x5} then 0x3C -> CH_DAC[5]=0x3C, all other channels 0x80. WR_DONE pulses exactly once, SYNC_STAGES+2 cycles after the second STB rise. BUSY is high between the two bytes.
- Globals and broadcasts:
  - Header 0x20, data 0x07 -> NEG_POL=AGND_INT_DISABLE=GEN=1.
  - Header 0x30, data 0xA5 -> all 16 DAC = 0xA5.
  - Header 0x40, data 0x01 -> CH_EN=16'hFFFF.
  - Header 0xF0, data 0x00 -> all values return to reset, ERR unchanged.
- Timeout: header 0x03 with no further STB for 1024 cycles -> FSM returns to IDLE, ERR=1, BUSY=0, CH_DAC[3] unchanged.
  - Follow with header 0xE0, data 0x00 -> ERR=0.
  - Follow with header 0x03, data 0x11 -> CH_DAC[3]=0x11.
- Illegal mode: header 0x75, data 0xFF -> no register change, WR_DONE pulses, ERR=1.
- Reset mid-frame and asynchrony:
  - Header 0x02, RST asserted before the data byte, then data 0x55 -> CH_DAC[2]=0x80. The 0x55 is treated as a new header (mode 5, illegal path pending).
  - Randomise STB phase against CLK over 200 frames -> all writes match a reference model.
